// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU.
// Round-robin grant, one operation in flight, with the result held until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,

  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             zero,
  input  logic             bge,
  input  logic             lt,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_bge,
  output logic             rsp_lt,

  output logic             busy
);

  localparam int unsigned OpW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OpW-1:0]   op_q, op_d;
  logic             id_q, id_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             bge_q, bge_d;
  logic             lt_q, lt_d;
  logic             rid_q, rid_d;

  logic             gnt0;
  logic             gnt1;

  // Grant is only offered in IDLE; rst gates it so nothing is accepted while held in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst && (state_q == IDLE)) begin
      gnt0 = req0_valid && (!req1_valid || !ptr_q);
      gnt1 = req1_valid && (!req0_valid ||  ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      bge_q   <= 1'b0;
      lt_q    <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      bge_q   <= bge_d;
      lt_q    <= lt_d;
      rid_q   <= rid_d;
    end
  end

  // Next-state: latch winner on accept, capture ALU in EXEC, wait for consumer in RESP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    res_d   = res_q;
    zero_d  = zero_q;
    bge_d   = bge_q;
    lt_d    = lt_q;
    rid_d   = rid_q;

    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a  : req0_a;
          b_d     = gnt1 ? req1_b  : req0_b;
          op_d    = gnt1 ? req1_op : req0_op;
          id_d    = gnt1;
          ptr_d   = !gnt1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = ALUResult;
        zero_d  = zero;
        bge_d   = bge;
        lt_d    = lt;
        rid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // ALU is fed only from the latched request so it never sees requester churn.
  assign SrcA       = a_q;
  assign SrcB       = b_q;
  assign ALUControl = op_q;

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rid_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_bge    = bge_q;
  assign rsp_lt     = lt_q;

  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single transactions plus
// hand-written backpressure and mid-operation reset sequences.
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] SrcA, SrcB;
  logic [2:0]   ALUControl;
  logic [W-1:0] ALUResult;
  logic         zero, bge, lt;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_bge, rsp_lt;
  logic         busy;

  int n_checks;
  int n_errors;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .zero       (zero),
    .bge        (bge),
    .lt         (lt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_bge    (rsp_bge),
    .rsp_lt     (rsp_lt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in: 0 add, 1 sub, 2 and, 3 or, others produce 0.
  always_comb begin
    case (ALUControl)
      3'd0:    ALUResult = SrcA + SrcB;
      3'd1:    ALUResult = SrcA - SrcB;
      3'd2:    ALUResult = SrcA & SrcB;
      3'd3:    ALUResult = SrcA | SrcB;
      default: ALUResult = '0;
    endcase
    zero = (ALUResult == '0);
    lt   = ($signed(SrcA) < $signed(SrcB));
    bge  = !lt;
  end

  typedef struct {
    logic         v0;
    logic         v1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [2:0]   op0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [2:0]   op1;
    logic         eid;
    logic [W-1:0] eres;
    logic         ez;
    logic         elt;
    logic         ebge;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic v1,
                              input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                              input logic eid, input logic [W-1:0] eres,
                              input logic ez, input logic elt, input logic ebge);
    vec_t v;
    v.v0 = v0; v.v1 = v1;
    v.a0 = a0; v.b0 = b0; v.op0 = op0;
    v.a1 = a1; v.b1 = b1; v.op1 = op1;
    v.eid = eid; v.eres = eres;
    v.ez = ez; v.elt = elt; v.ebge = ebge;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts and ends on a falling edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    logic [W-1:0] ea, eb;
    logic [2:0]   eop;
    ea  = v.eid ? v.a1  : v.a0;
    eb  = v.eid ? v.b1  : v.b0;
    eop = v.eid ? v.op1 : v.op0;
    rsp_ready  = 1'b1;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    #1;
    chk($sformatf("v%0d grant", idx), W'({req1_ready, req0_ready}), v.eid ? W'(2) : W'(1));
    @(posedge clk); #1;
    if (v.eid) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d exec busy", idx), W'(busy), W'(1));
    chk($sformatf("v%0d exec rsp_valid", idx), W'(rsp_valid), W'(0));
    chk($sformatf("v%0d exec readys", idx), W'({req1_ready, req0_ready}), W'(0));
    chk($sformatf("v%0d SrcA", idx), SrcA, ea);
    chk($sformatf("v%0d SrcB", idx), SrcB, eb);
    chk($sformatf("v%0d ALUControl", idx), W'(ALUControl), W'(eop));
    @(negedge clk);
    chk($sformatf("v%0d rsp_valid", idx), W'(rsp_valid), W'(1));
    chk($sformatf("v%0d rsp_id", idx), W'(rsp_id), W'(v.eid));
    chk($sformatf("v%0d rsp_result", idx), rsp_result, v.eres);
    chk($sformatf("v%0d rsp_zero", idx), W'(rsp_zero), W'(v.ez));
    chk($sformatf("v%0d rsp_lt", idx), W'(rsp_lt), W'(v.elt));
    chk($sformatf("v%0d rsp_bge", idx), W'(rsp_bge), W'(v.ebge));
    chk($sformatf("v%0d resp readys", idx), W'({req1_ready, req0_ready}), W'(0));
    @(negedge clk);
    chk($sformatf("v%0d idle rsp_valid", idx), W'(rsp_valid), W'(0));
    chk($sformatf("v%0d idle busy", idx), W'(busy), W'(0));
    chk($sformatf("v%0d idle ALUControl", idx), W'(ALUControl), W'(eop));
  endtask

  vec_t vecs[10];

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Pointer resets to 0: contention goes req0, req1, req0, req1.
    vecs[0] = mk(1, 1, 137, 134, 3'd1, 134, 134, 3'd0, 0, 32'd3,   0, 0, 1);
    vecs[1] = mk(1, 1, 137, 134, 3'd1, 134, 134, 3'd0, 1, 32'd268, 0, 0, 1);
    vecs[2] = mk(1, 1, 137, 134, 3'd1, 134, 134, 3'd0, 0, 32'd3,   0, 0, 1);
    vecs[3] = mk(1, 1, 137, 134, 3'd1, 134, 134, 3'd0, 1, 32'd268, 0, 0, 1);
    vecs[4] = mk(1, 0, 137, 134, 3'd0, 0,   0,   3'd0, 0, 32'd271, 0, 0, 1);
    vecs[5] = mk(0, 1, 0,   0,   3'd0, 134, 134, 3'd1, 1, 32'd0,   1, 0, 1);
    vecs[6] = mk(0, 1, 0,   0,   3'd0, 134, 198, 3'd1, 1, 32'hFFFF_FFC0, 0, 1, 0);
    vecs[7] = mk(1, 0, 5,   3,   3'd7, 0,   0,   3'd0, 0, 32'd0,   1, 0, 1);
    vecs[8] = mk(0, 1, 0,   0,   3'd0, 32'hF0F0, 32'h0FF0, 3'd2, 1, 32'h00F0, 0, 0, 1);
    vecs[9] = mk(1, 1, 137, 134, 3'd1, 134, 134, 3'd0, 0, 32'd3,   0, 0, 1);

    // Reset held with both requesters pushing: nothing may leak out.
    rst = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd22; req0_op = 3'd3;
    req1_valid = 1'b1; req1_a = 32'd33; req1_b = 32'd44; req1_op = 3'd2;
    @(negedge clk);
    chk("rst req0_ready", W'(req0_ready), W'(0));
    chk("rst req1_ready", W'(req1_ready), W'(0));
    chk("rst busy", W'(busy), W'(0));
    chk("rst rsp_valid", W'(rsp_valid), W'(0));
    chk("rst SrcA", SrcA, W'(0));
    chk("rst SrcB", SrcB, W'(0));
    chk("rst ALUControl", W'(ALUControl), W'(0));
    chk("rst rsp_result", rsp_result, W'(0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: response must freeze while rsp_ready is low, with a second requester waiting.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd7; req0_op = 3'd1;
    req1_valid = 1'b0;
    #1;
    chk("bp grant", W'({req1_ready, req0_ready}), W'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'd0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", k), W'(rsp_valid), W'(1));
      chk($sformatf("bp%0d rsp_result", k), rsp_result, W'(3));
      chk($sformatf("bp%0d rsp_id", k), W'(rsp_id), W'(0));
      chk($sformatf("bp%0d busy", k), W'(busy), W'(1));
      chk($sformatf("bp%0d readys", k), W'({req1_ready, req0_ready}), W'(0));
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp handshake readys", W'({req1_ready, req0_ready}), W'(0));
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp released rsp_valid", W'(rsp_valid), W'(0));
    chk("bp released busy", W'(busy), W'(0));
    @(negedge clk);
    chk("bp withdrawn valid ignored", W'(busy), W'(0));

    // Reset in EXEC aborts the operation; pointer returns to requester 0.
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22; req0_op = 3'd3;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1;
    chk("mid busy before rst", W'(busy), W'(1));
    rst = 1'b0;
    #1;
    chk("mid rst busy", W'(busy), W'(0));
    chk("mid rst rsp_valid", W'(rsp_valid), W'(0));
    chk("mid rst readys", W'({req1_ready, req0_ready}), W'(0));
    chk("mid rst SrcA", SrcA, W'(0));
    chk("mid rst SrcB", SrcB, W'(0));
    chk("mid rst ALUControl", W'(ALUControl), W'(0));
    chk("mid rst rsp_result", rsp_result, W'(0));
    chk("mid rst rsp_id", W'(rsp_id), W'(0));
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post rst%0d rsp_valid", k), W'(rsp_valid), W'(0));
    end
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'd1;
    #1;
    chk("post rst grant req0", W'({req1_ready, req0_ready}), W'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post rst rsp_valid", W'(rsp_valid), W'(1));
    chk("post rst rsp_result", rsp_result, W'(5));
    chk("post rst rsp_id", W'(rsp_id), W'(0));
    @(negedge clk);
    chk("post rst idle", W'(busy), W'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (fixed to the shared ALU width).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester n.
REQ-007 The block SHALL have ports req0_op / req1_op  input  3  ALU operation code of requester n.
REQ-008 The block SHALL have ports SrcA, SrcB  output  WIDTH  and ALUControl  output  3, driving the shared ALU.
REQ-009 The block SHALL have ports ALUResult  input  WIDTH  and zero, bge, lt  input  1 each, returned by the shared ALU.
REQ-010 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (0 = requester 0, 1 = requester 1).
REQ-011 The block SHALL have ports rsp_result  output  WIDTH  and rsp_zero, rsp_bge, rsp_lt  output  1 each, carrying the captured ALU outputs.
REQ-012 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-014 In IDLE, grant SHALL be combinational: one valid -> that requester; both valid -> requester selected by the round-robin pointer; none -> no grant.
REQ-015 reqN_ready SHALL be high only in IDLE and only for the granted requester; the two readys SHALL never be high together.
REQ-016 On reqN_valid & reqN_ready, the operands, op and id SHALL be latched into internal registers, the state SHALL go to EXEC, and the pointer SHALL move to the other requester.
REQ-017 The pointer SHALL update only on an accepted handshake; an uncontested grant also moves it.
REQ-018 SrcA, SrcB and ALUControl SHALL always be driven from the latched registers, never directly from requester inputs.
REQ-019 In EXEC (exactly one cycle), ALUResult, zero, bge and lt SHALL be captured into the response registers, and the state SHALL go to RESP.
REQ-020 In RESP, rsp_valid SHALL be high, and rsp_id/rsp_result/rsp_zero/rsp_bge/rsp_lt SHALL be held stable until rsp_valid & rsp_ready.
REQ-021 On the rsp handshake, the state SHALL return to IDLE, with rsp_valid low the next cycle; no new request SHALL be accepted in the handshake cycle.
REQ-022 Latency from request acceptance to rsp_valid SHALL be 2 cycles; minimum spacing between accepted requests SHALL be 3 cycles.
REQ-023 Requesters SHALL hold valid and operands stable until ready; a valid deasserted before ready SHALL be ignored without error.
REQ-024 All 3-bit op codes, including 3'd7, SHALL pass to ALUControl unchanged; the block SHALL not interpret them.
REQ-025 A backpressured RESP (rsp_ready low) SHALL stall indefinitely, with reqN_ready held low throughout.

Reset
REQ-026 While rst is low: state = IDLE, pointer = 0, all latched and response registers = 0, and rsp_valid, req0_ready, req1_ready, busy = 0.
REQ-027 SrcA, SrcB and ALUControl SHALL read 0 during reset.
REQ-028 Assertion of rst in EXEC or RESP SHALL abort the transaction immediately, with no response issued for it after release.
REQ-029 After rst deasserts, the first cycle SHALL be IDLE, and requester 0 SHALL win if both requesters are valid.

Verification
REQ-030 Single request: req0 a=137, b=134, op=3'd0 (add) with rsp_ready=1 -> accepted in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_result=271, rsp_zero=0.
REQ-031 Contention: both valid after reset (req0 op=3'd1 sub 137-134, req1 op=3'd0 134+134) -> order is req0 then req1, giving rsp_result 3 then 268; the pointer alternates on repeated contention.
REQ-032 Flags: req1 a=134, b=134, op=3'd1 -> rsp_zero=1, rsp_id=1; with a=134, b=198 -> rsp_lt=1, rsp_bge=0.
REQ-033 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> response fields stable, busy=1, both readys 0; releasing rsp_ready -> IDLE the next cycle.
REQ-034 Reset mid-op: assert rst in EXEC -> all outputs 0 asynchronously, no rsp_valid after release, and the next request is served normally.
REQ-035 Op pass-through: op=3'd7 -> ALUControl=3'd7 from EXEC until the next acceptance.
